// File: rtl/lms_pkg.sv
// Shared definitions for the LMS adaptive filter forward path.
// Provides the datapath widths, the forward-path FSM state encoding and
// the 14-bit saturation helper used by the output and error stages.
package lms_pkg;

  localparam int TAPS     = 16;
  localparam int SAMPLE_W = 14;
  localparam int WEIGHT_W = 32;
  localparam int FRAC_W   = 24;
  localparam int PROD_W   = SAMPLE_W + WEIGHT_W;  // 46-bit signed product
  localparam int ACC_W    = 50;                   // product plus 4 guard bits for 16 taps
  localparam int IDX_W    = 4;
  localparam int DIV_LAT  = 2;
  localparam int CNT_W    = 2;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TAPS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LAT - 1);

  localparam logic signed [ACC_W-1:0]    SAT_HI_ACC = 50'sd8191;
  localparam logic signed [ACC_W-1:0]    SAT_LO_ACC = -50'sd8192;
  localparam logic signed [SAMPLE_W-1:0] SAT_HI     = 14'sh1FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_LO     = 14'sh2000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2,
    ST_WAIT = 2'd3
  } lms_state_e;

  // Clamp a wide signed value into the 14-bit sample range [-8192, 8191].
  function automatic logic signed [SAMPLE_W-1:0] sat14(input logic signed [ACC_W-1:0] v);
    if (v > SAT_HI_ACC) begin
      return SAT_HI;
    end else if (v < SAT_LO_ACC) begin
      return SAT_LO;
    end else begin
      return v[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/lms_fir_mac_if.sv
// Sample/result bus between the LMS forward path and its neighbours.
// master: sample source and weight-update side (drives samples and weights).
// slave : lms_fir_mac (drives handshake ready, tap line, y_out, e and strobes).
interface lms_fir_mac_if;
  import lms_pkg::*;

  logic                              sample_valid;
  logic                              sample_ready;
  logic signed [SAMPLE_W-1:0]        x_in;
  logic signed [SAMPLE_W-1:0]        d_in;
  logic [TAPS*WEIGHT_W-1:0]          weights_flat;
  logic [TAPS*SAMPLE_W-1:0]          reff_flat;
  logic signed [SAMPLE_W-1:0]        y_out;
  logic signed [SAMPLE_W-1:0]        e;
  logic                              e_valid;
  logic                              weight_cal_state;

  modport master (
    output sample_valid, x_in, d_in, weights_flat,
    input  sample_ready, reff_flat, y_out, e, e_valid, weight_cal_state
  );

  modport slave (
    input  sample_valid, x_in, d_in, weights_flat,
    output sample_ready, reff_flat, y_out, e, e_valid, weight_cal_state
  );

endinterface

// File: rtl/lms_tap_line.sv
// Reference-sample delay line: TAPS x SAMPLE_W shift register.
// Ports: clk, rst (async active-high), shift_en (shift one position),
//        din (new newest sample), taps_flat (tap k at [14k+13:14k], tap 0 newest).
module lms_tap_line
  import lms_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_en,
  input  logic [SAMPLE_W-1:0]      din,
  output logic [TAPS*SAMPLE_W-1:0] taps_flat
);

  logic [TAPS*SAMPLE_W-1:0] taps_q;
  logic [TAPS*SAMPLE_W-1:0] taps_d;

  // Next tap line: oldest sample drops off the top, din enters at tap 0.
  always_comb begin
    taps_d = taps_q;
    if (shift_en) begin
      taps_d = {taps_q[(TAPS-1)*SAMPLE_W-1:0], din};
    end else begin
      taps_d = taps_q;
    end
  end

  // Tap line register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps_q <= {(TAPS*SAMPLE_W){1'b0}};
    end else begin
      taps_q <= taps_d;
    end
  end

  assign taps_flat = taps_q;

endmodule

// File: rtl/lms_fir_mac.sv
// LMS forward path: y = sum(w_k * reff_k) >>> FRAC_W with one shared MAC
// (16 cycles per sample), error e = d - y, and the weight-update strobe.
// Ports: clk, rst (async active-high), bus (lms_fir_mac_if.slave):
//   sample_valid/sample_ready handshake with x_in/d_in, weights_flat in,
//   reff_flat tap line out, y_out/e results with e_valid, weight_cal_state strobe.
// Timing for a sample accepted at edge T: e_valid registered at T+17,
// weight_cal_state registered at T+17+DIV_LAT, next acceptance possible at T+20.
module lms_fir_mac
  import lms_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  lms_fir_mac_if.slave bus
);

  lms_state_e                 state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic signed [SAMPLE_W-1:0] dsmp_q, dsmp_d;
  logic signed [SAMPLE_W-1:0] y_q, y_d;
  logic signed [SAMPLE_W-1:0] e_q, e_d;
  logic                       e_valid_q, e_valid_d;
  logic                       wcal_q, wcal_d;
  logic                       ready_q, ready_d;
  logic                       shift_en_s;

  logic [TAPS*SAMPLE_W-1:0]   reff_s;
  logic signed [SAMPLE_W-1:0] x_sel_s;
  logic signed [WEIGHT_W-1:0] w_sel_s;
  logic signed [PROD_W-1:0]   prod_s;
  logic signed [ACC_W-1:0]    prod_ext_s;
  logic signed [ACC_W-1:0]    y_full_s;
  logic signed [SAMPLE_W-1:0] y_s;
  logic signed [SAMPLE_W:0]   diff_s;
  logic signed [SAMPLE_W-1:0] e_s;

  lms_tap_line u_tap_line (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en_s),
    .din       (bus.x_in),
    .taps_flat (reff_s)
  );

  // Tap-index mux: the MAC walks tap/weight pairs 0..15, one per cycle.
  assign x_sel_s = $signed(reff_s[idx_q*SAMPLE_W +: SAMPLE_W]);
  assign w_sel_s = $signed(bus.weights_flat[idx_q*WEIGHT_W +: WEIGHT_W]);

  // Both operands sign-extended to the full product width before multiplying.
  assign prod_s = $signed({{(PROD_W-WEIGHT_W){w_sel_s[WEIGHT_W-1]}}, w_sel_s}) *
                  $signed({{(PROD_W-SAMPLE_W){x_sel_s[SAMPLE_W-1]}}, x_sel_s});
  assign prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};

  // Output stage: arithmetic shift floors toward -inf, then clamp; error at 15 bits.
  assign y_full_s = acc_q >>> FRAC_W;
  assign y_s      = sat14(y_full_s);
  assign diff_s   = {dsmp_q[SAMPLE_W-1], dsmp_q} - {y_s[SAMPLE_W-1], y_s};
  assign e_s      = sat14({{(ACC_W-SAMPLE_W-1){diff_s[SAMPLE_W]}}, diff_s});

  // FSM next-state and datapath next values.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    dsmp_d     = dsmp_q;
    y_d        = y_q;
    e_d        = e_q;
    e_valid_d  = 1'b0;
    wcal_d     = 1'b0;
    shift_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.sample_valid) begin
          shift_en_s = 1'b1;
          dsmp_d     = bus.d_in;
          acc_d      = {ACC_W{1'b0}};
          idx_d      = {IDX_W{1'b0}};
          state_d    = ST_MAC;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + prod_ext_s;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_MAC;
        end
      end
      ST_DONE: begin
        y_d       = y_s;
        e_d       = e_s;
        e_valid_d = 1'b1;
        cnt_d     = {CNT_W{1'b0}};
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // e stays stable for DIV_LAT cycles so the divider settles before the strobe.
        if (cnt_q == CNT_LAST) begin
          wcal_d  = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= {IDX_W{1'b0}};
      acc_q     <= {ACC_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      dsmp_q    <= {SAMPLE_W{1'b0}};
      y_q       <= {SAMPLE_W{1'b0}};
      e_q       <= {SAMPLE_W{1'b0}};
      e_valid_q <= 1'b0;
      wcal_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      dsmp_q    <= dsmp_d;
      y_q       <= y_d;
      e_q       <= e_d;
      e_valid_q <= e_valid_d;
      wcal_q    <= wcal_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.sample_ready     = ready_q;
  assign bus.reff_flat        = reff_s;
  assign bus.y_out            = y_q;
  assign bus.e                = e_q;
  assign bus.e_valid          = e_valid_q;
  assign bus.weight_cal_state = wcal_q;

endmodule
